// File: rtl/exp2_pkg.sv
// Shared widths, range limits and the stage-register layout for the base-2 exponent pipeline.
// The datapath widths are fixed here; every file of the unit takes them from this package.
package exp2_pkg;

  localparam int FIX_POINT_WIDTH = 16;
  localparam int BF              = 8;
  localparam int TAG_W           = 4;

  localparam int K_W = FIX_POINT_WIDTH - BF;
  localparam int M_W = BF + 1;

  // Largest integer exponent whose (1+f)<<k still fits below the sign bit.
  localparam int K_OVF_LIM = FIX_POINT_WIDTH - 2 - BF;
  localparam int K_UDF_LIM = -(BF + 1);

  localparam logic [FIX_POINT_WIDTH-1:0] MAX_POS = {1'b0, {(FIX_POINT_WIDTH-1){1'b1}}};
  localparam logic [M_W-1:0]             M_ONE   = {1'b1, {BF{1'b0}}};

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic signed [K_W-1:0] k;
    logic [M_W-1:0]        m;
    logic                  ovf;
    logic                  udf;
  } stage_t;

  function automatic logic k_ovf(input logic signed [K_W-1:0] k);
    return int'(k) > K_OVF_LIM;
  endfunction

  function automatic logic k_udf(input logic signed [K_W-1:0] k);
    return int'(k) < K_UDF_LIM;
  endfunction

endpackage

// File: rtl/exp2_shift.sv
// Combinational saturating bidirectional shifter: scales the mantissa m by 2^k,
// clamping to MAX_POS on overflow and to zero on underflow.
module exp2_shift
  import exp2_pkg::*;
(
  input  logic [M_W-1:0]             m,
  input  logic signed [K_W-1:0]      k,
  input  logic                       ovf,
  input  logic                       udf,
  output logic [FIX_POINT_WIDTH-1:0] result
);

  logic [FIX_POINT_WIDTH-1:0] m_ext;
  logic [K_W-1:0]             k_mag;

  always_comb begin
    m_ext = FIX_POINT_WIDTH'(m);
    k_mag = k[K_W-1] ? K_W'(-k) : K_W'(k);
    if (ovf) begin
      result = MAX_POS;
    end else if (udf) begin
      result = '0;
    end else if (k[K_W-1]) begin
      // Right shift truncates: fractional bits below the output LSB are dropped.
      result = m_ext >> k_mag;
    end else begin
      result = m_ext << k_mag;
    end
  end

endmodule

// File: rtl/exp2_pipe.sv
// Three-stage Mitchell 2^y unit: split y into k/f, form m=1+f with range flags,
// then shift and saturate into the output register. One global advance enable.
module exp2_pipe
  import exp2_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]           out_tag
);

  // Handshake: a beat transfers on valid && ready at either port. The whole pipe
  // advances when the output register is empty or being drained; otherwise every
  // stage, including the output, holds. in_ready depends only on registered state
  // and out_ready, never on in_valid.
  logic adv;

  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;

  logic                       out_valid_q, out_valid_d;
  logic [FIX_POINT_WIDTH-1:0] out_data_q,  out_data_d;
  logic [TAG_W-1:0]           out_tag_q,   out_tag_d;

  logic [FIX_POINT_WIDTH-1:0] shift_result;

  exp2_shift u_shift (
    .m      (s2_q.m),
    .k      (s2_q.k),
    .ovf    (s2_q.ovf),
    .udf    (s2_q.udf),
    .result (shift_result)
  );

  always_comb begin
    adv         = out_ready || !out_valid_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;

    if (adv) begin
      // Upper bits of the fixed-point word are already floor(y); the low bits are f.
      s1_d.valid = in_valid;
      s1_d.tag   = in_tag;
      s1_d.k     = in_data[FIX_POINT_WIDTH-1:BF];
      s1_d.m     = M_W'(in_data[BF-1:0]);
      s1_d.ovf   = 1'b0;
      s1_d.udf   = 1'b0;

      // Range flags are sticky so any earlier stage could raise them too.
      s2_d.valid = s1_q.valid;
      s2_d.tag   = s1_q.tag;
      s2_d.k     = s1_q.k;
      s2_d.m     = s1_q.m + M_ONE;
      s2_d.ovf   = s1_q.ovf | k_ovf(s1_q.k);
      s2_d.udf   = s1_q.udf | k_udf(s1_q.k);

      out_valid_d = s2_q.valid;
      out_data_d  = shift_result;
      out_tag_d   = s2_q.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_exp2_pipe.sv
// Self-checking bench for exp2_pipe: exact points, saturation, backpressure,
// bubbles, mid-stream reset and an exhaustive input sweep against an arithmetic model.
module tb_exp2_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  tag_q[$];

  always #5 clk = ~clk;

  exp2_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // 2^y with y in Q8.8: y = k + f/256, result = (256+f)*2^k in Q8.8, clamped.
  function automatic logic [15:0] exp2_model(input logic [15:0] y);
    int yv, f, k, m;
    yv = int'($signed(y));
    f  = yv & 255;
    k  = (yv - f) / 256;
    m  = 256 + f;
    if (k > 6)  return 16'h7FFF;
    if (k < -9) return 16'h0000;
    if (k >= 0) return 16'(m * (1 << k));
    return 16'(m / (1 << (-k)));
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h expected 0000", out_data);
    else n_pass++;
    n_checks++;
    if (out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h expected 0", out_tag);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_exact_points();
    logic [15:0] vin [10];
    logic [15:0] vexp[10];
    logic [15:0] got_d;
    logic [3:0]  got_t;
    int          lat;
    vin  = '{16'h0000, 16'h0100, 16'hFF00, 16'h0080, 16'hFF80,
             16'h0680, 16'h0700, 16'h7FFF, 16'hF700, 16'h8000};
    vexp = '{16'h0100, 16'h0200, 16'h0080, 16'h0180, 16'h00C0,
             16'h6000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = vin[i];
      in_tag    = 4'(i + 3);
      out_ready = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      lat   = 0;
      got_d = 'x;
      got_t = 'x;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (out_valid === 1'b1 && lat == 0) begin
          lat   = n;
          got_d = out_data;
          got_t = out_tag;
        end
        next_cycle();
      end
      n_checks++;
      if (lat != 3) $display("FAIL exact_latency[%h]: got %0d cycles expected 3", vin[i], lat);
      else n_pass++;
      n_checks++;
      if (got_d !== vexp[i]) $display("FAIL exact_data[%h]: got %h expected %h", vin[i], got_d, vexp[i]);
      else n_pass++;
      n_checks++;
      if (got_t !== 4'(i + 3)) $display("FAIL exact_tag[%h]: got %h expected %h", vin[i], got_t, 4'(i + 3));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int got = 0;
    exp_q.delete();
    tag_q.delete();
    for (int c = 0; c < 30; c++) begin
      in_valid  = (idx < 8);
      in_data   = 16'($urandom);
      in_tag    = 4'(idx);
      out_ready = !(c >= 4 && c <= 7);
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready == 1'b0) begin
        // Held result must still be the oldest outstanding sample.
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, in_ready);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0] || out_tag !== tag_q[0])
          $display("FAIL stall_hold c=%0d: got %h/%h expected %h/%h", c, out_data, out_tag,
                   (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, (tag_q.size() != 0) ? tag_q[0] : 4'hx);
        else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready == 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h/%h expected nothing", out_data, out_tag);
        else begin
          if (out_data !== exp_q[0] || out_tag !== tag_q[0])
            $display("FAIL b2b_data: got %h/%h expected %h/%h", out_data, out_tag, exp_q[0], tag_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(exp2_model(in_data));
        tag_q.push_back(in_tag);
        idx++;
      end
      next_cycle();
    end
    n_checks++;
    if (got != 8 || idx != 8) $display("FAIL b2b_count: got %0d out of %0d sent expected 8/8", got, idx);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    logic hist[$];
    exp_q.delete();
    tag_q.delete();
    for (int c = 0; c < 64; c++) begin
      in_valid  = (c < 56) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 16'($urandom);
      in_tag    = 4'($urandom);
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== ((c >= 3) ? hist[c-3] : 1'b0))
        $display("FAIL bubble_valid c=%0d: got %b expected %b", c, out_valid, (c >= 3) ? hist[c-3] : 1'b0);
      else n_pass++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bubble_extra: got %h expected nothing", out_data);
        else begin
          if (out_data !== exp_q[0] || out_tag !== tag_q[0])
            $display("FAIL bubble_data: got %h/%h expected %h/%h", out_data, out_tag, exp_q[0], tag_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
      end
      hist.push_back(in_valid);
      if (in_valid) begin
        exp_q.push_back(exp2_model(in_data));
        tag_q.push_back(in_tag);
      end
      next_cycle();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bubble_drain: got %0d left expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int emitted = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_tag   = 4'(10 + c);
      next_cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    next_cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      if (out_valid !== 1'b0) emitted++;
    end
    next_cycle();
    n_checks++;
    if (emitted != 0) $display("FAIL rstmid_flushed: got %0d outputs expected 0", emitted);
    else n_pass++;
  endtask

  task automatic test_sweep();
    int idx = 0;
    int got = 0;
    exp_q.delete();
    tag_q.delete();
    for (int c = 0; c < 65536 + 50 && got < 65536; c++) begin
      in_valid  = (idx < 65536);
      in_data   = 16'(idx);
      in_tag    = 4'(idx);
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL sweep_extra: got %h expected nothing", out_data);
        else begin
          if (out_data !== exp_q[0] || out_tag !== tag_q[0])
            $display("FAIL sweep_data[%0d]: got %h/%h expected %h/%h", got, out_data, out_tag, exp_q[0], tag_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(exp2_model(in_data));
        tag_q.push_back(in_tag);
        idx++;
      end
      next_cycle();
    end
    n_checks++;
    if (got != 65536) $display("FAIL sweep_count: got %0d expected 65536", got);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_exact_points();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
